// File: rtl/rv_pkg.sv
// Shared rv32 front-end types: data widths, canonical NOP and the fetch entry payload.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  // One fetched instruction tagged with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the two low bits so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of fetch entries; flush beats push and pop, head is read combinationally.
module if_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]        wptr_q;
  logic [PTR_W-1:0]        rptr_q;
  logic [CNT_W-1:0]        count_q;
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// rv32 instruction-fetch stage: owns the PC, issues credit-limited in-order word fetches,
// buffers responses in a prefetch FIFO and hands them to decode over valid/ready.
// Redirects from execute flush the FIFO and discard responses still in flight.
// Optional macro IF_MISALIGN_CHK_EN: misaligned redirects halt fetch and raise id_misaligned.
module if_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        id_misaligned
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef IF_MISALIGN_CHK_EN
    ,
    ST_HALT = 2'd2
`endif
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              fifo_empty;
  logic              fifo_full;
  logic              gnt_fire;
  logic              resp_push;
  logic              fifo_push;
  logic              fifo_pop;
  logic [XLEN-1:0]   redirect_tgt;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

`ifdef IF_MISALIGN_CHK_EN
  logic              misaligned_q;
  logic              redirect_mis;
  assign redirect_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign id_misaligned = misaligned_q;
`endif

  // Credit: fetches in flight plus buffered words never exceed the FIFO depth.
  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req     = (state_q == ST_RUN) && !redirect_valid &&
                        (credit_used < (CNT_W + 1)'(DEPTH));
  assign imem_addr    = pc_q;
  assign gnt_fire     = imem_req && imem_gnt;
  assign redirect_tgt = word_align(redirect_pc);

  // Responses are kept only once all stale in-flight words have been discarded.
  assign resp_push  = imem_rvalid && (discard_q == '0) && !redirect_valid;
  assign fifo_push  = resp_push && !fifo_full;
  assign fifo_pop   = id_valid && id_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

  assign id_valid = !fifo_empty;
  assign id_instr = head_entry.instr;
  assign id_pc    = head_entry.pc;

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next PC, response PC, in-flight and discard counters; redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
    if (gnt_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
    if (redirect_valid) begin
      pc_d      = redirect_tgt;
      resp_pc_d = redirect_tgt;
      discard_d = inflight_q - CNT_W'(imem_rvalid);
    end else if (imem_rvalid) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CNT_W'(1);
      end else begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  // Control FSM: one IDLE cycle after reset, then RUN (HALT on a misaligned redirect).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
`ifdef IF_MISALIGN_CHK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        default: state_q <= state_q;
      endcase
`ifdef IF_MISALIGN_CHK_EN
      if (redirect_valid) begin
        if (redirect_mis) begin
          state_q      <= ST_HALT;
          misaligned_q <= 1'b1;
        end else begin
          state_q      <= ST_RUN;
          misaligned_q <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small in-order instruction memory model
// whose response latency is selectable (1..3 cycles after grant); rdata = ~addr.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef IF_MISALIGN_CHK_EN
  logic        id_misaligned;
`endif

  int checks = 0;
  int failures = 0;
  int lat = 1;

  logic [3:0]  pv;
  logic [31:0] pa [4];

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .id_misaligned  (id_misaligned)
`endif
  );

  // Memory model: granted address enters a shift pipe at stage lat-1, responds from stage 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pv[i] <= pv[i+1];
        pa[i] <= pa[i+1];
      end
      pv[3] <= 1'b0;
      if (imem_req && imem_gnt) begin
        pv[lat-1] <= 1'b1;
        pa[lat-1] <= imem_addr;
      end
    end
  end

  assign imem_rvalid = pv[0];
  assign imem_rdata  = pv[0] ? ~pa[0] : 32'h0;

  // A push must never meet a full FIFO.
  always @(negedge clk) begin
    if (rst_n && dut.resp_push && dut.fifo_full) begin
      $display("FAIL fifo_overflow: push with full=1, required full=0");
      failures++;
    end
  end

  task automatic do_reset(input int new_lat);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    imem_gnt = 1'b1;
    lat = new_lat;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin $display("FAIL reset_req: got %b, required 0", imem_req); failures++; end
    checks++;
    if (id_valid !== 1'b0) begin $display("FAIL reset_id_valid: got %b, required 0", id_valid); failures++; end
    checks++;
    if (id_instr !== 32'h0) begin $display("FAIL reset_id_instr: got %h, required 0", id_instr); failures++; end
    checks++;
    if (id_pc !== 32'h0) begin $display("FAIL reset_id_pc: got %h, required 0", id_pc); failures++; end
    checks++;
    if (imem_addr !== 32'h0) begin $display("FAIL reset_addr: got %h, required 0", imem_addr); failures++; end
`ifdef IF_MISALIGN_CHK_EN
    checks++;
    if (id_misaligned !== 1'b0) begin $display("FAIL reset_misaligned: got %b, required 0", id_misaligned); failures++; end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    logic [31:0] ep;
    int pops;
    ea = 32'h0;
    ep = 32'h0;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          $display("FAIL stream_first_req: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
          failures++;
        end
      end
      if (imem_req && imem_gnt) begin
        checks++;
        if (imem_addr !== ea) begin $display("FAIL stream_addr: got %h, required %h", imem_addr, ea); failures++; end
        ea = ea + 32'd4;
      end
      if (id_valid) begin
        checks++;
        if (id_pc !== ep || id_instr !== ~ep) begin
          $display("FAIL stream_id: got pc=%h instr=%h, required pc=%h instr=%h", id_pc, id_instr, ep, ~ep);
          failures++;
        end
        ep = ep + 32'd4;
        pops++;
      end
    end
    checks++;
    if (pops !== 10) begin $display("FAIL stream_throughput: got %0d pops, required 10", pops); failures++; end
  endtask

  task automatic test_backpressure();
    int grants;
    logic [31:0] ep;
    do_reset(1);
    id_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) grants++;
    end
    checks++;
    if (grants !== 4) begin $display("FAIL bp_grants: got %0d, required 4", grants); failures++; end
    checks++;
    if (imem_req !== 1'b0) begin $display("FAIL bp_req_low: got %b, required 0", imem_req); failures++; end
    checks++;
    if (dut.fifo_count !== 3'd4) begin $display("FAIL bp_count: got %0d, required 4", dut.fifo_count); failures++; end
    ep = 32'h0;
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== ep || id_instr !== ~ep) begin
        $display("FAIL bp_drain: got valid=%b pc=%h instr=%h, required valid=1 pc=%h", id_valid, id_pc, id_instr, ep);
        failures++;
      end
      ep = ep + 32'd4;
    end
  endtask

  task automatic test_redirect_inflight();
    int w;
    do_reset(3);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin $display("FAIL redir_req_low: got %b, required 0", imem_req); failures++; end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      $display("FAIL redir_refetch: got req=%b addr=%h valid=%b, required req=1 addr=100 valid=0",
               imem_req, imem_addr, id_valid);
      failures++;
    end
    w = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (id_valid) begin
        w = i;
        break;
      end
    end
    checks++;
    if (w !== 4) begin $display("FAIL redir_latency: got %0d cycles, required 4", w); failures++; end
    checks++;
    if (id_pc !== 32'h100 || id_instr !== ~32'h100) begin
      $display("FAIL redir_first: got pc=%h instr=%h, required pc=100 instr=%h", id_pc, id_instr, ~32'h100);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_rvalid !== 1'b1) begin
      $display("FAIL b2b_setup: got valid=%b pc=%h rvalid=%b, required 1/0/1", id_valid, id_pc, imem_rvalid);
      failures++;
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0) begin $display("FAIL b2b_flush1: got %b, required 0", id_valid); failures++; end
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      $display("FAIL b2b_refetch: got valid=%b req=%b addr=%h, required 0/1/300", id_valid, imem_req, imem_addr);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0) begin $display("FAIL b2b_gap: got %b, required 0", id_valid); failures++; end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_instr !== ~32'h300) begin
      $display("FAIL b2b_first: got valid=%b pc=%h instr=%h, required 1/300/%h", id_valid, id_pc, id_instr, ~32'h300);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h304) begin
      $display("FAIL b2b_second: got valid=%b pc=%h, required 1/304", id_valid, id_pc);
      failures++;
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_addr0: got req=%b addr=%h, required 1/fffffffc", imem_req, imem_addr);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h0) begin $display("FAIL wrap_addr1: got %h, required 0", imem_addr); failures++; end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h3) begin
      $display("FAIL wrap_id0: got valid=%b pc=%h instr=%h, required 1/fffffffc/3", id_valid, id_pc, id_instr);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hFFFF_FFFF) begin
      $display("FAIL wrap_id1: got valid=%b pc=%h instr=%h, required 1/0/ffffffff", id_valid, id_pc, id_instr);
      failures++;
    end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign();
    int w;
    do_reset(1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (id_misaligned !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
      $display("FAIL mis_halt: got mis=%b req=%b valid=%b, required 1/0/0", id_misaligned, imem_req, id_valid);
      failures++;
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0) begin $display("FAIL mis_no_req: got %b, required 0", imem_req); failures++; end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0104;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (id_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      $display("FAIL mis_resume: got mis=%b req=%b addr=%h, required 0/1/104", id_misaligned, imem_req, imem_addr);
      failures++;
    end
    w = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (id_valid) begin
        w = i;
        break;
      end
    end
    checks++;
    if (w !== 2 || id_pc !== 32'h104) begin
      $display("FAIL mis_first: got wait=%0d pc=%h, required 2/104", w, id_pc);
      failures++;
    end
  endtask
`else
  task automatic test_align_mask();
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      $display("FAIL mask_addr: got req=%b addr=%h, required 1/100", imem_req, imem_addr);
      failures++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      $display("FAIL mask_id_pc: got valid=%b pc=%h, required 1/100", id_valid, id_pc);
      failures++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_back_to_back();
    test_wrap();
`ifdef IF_MISALIGN_CHK_EN
    test_misalign();
`else
    test_align_mask();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
